// File: rtl/ram_arb_2p.sv
// Two-port arbiter and sequencer in front of a 16x8 synchronous RAM with 2-edge read return.
// Define RAM_ARB_FIXED_PRI_EN for fixed priority (port 0 wins); default is round-robin.
module ram_arb_2p #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_0,
   input  logic              req_1,
   input  logic              we_0,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              rvalid_0,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] rdata_0,
   output logic [DATA_W-1:0] rdata_1,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_rd_add,
   output logic [ADDR_W-1:0] ram_wr_add,
   output logic [DATA_W-1:0] ram_d_in,
   input  logic [DATA_W-1:0] ram_d_out
);

   logic              xfer_0;
   logic              xfer_1;
   logic              xfer;
   logic              sel_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic              trk1_v;
   logic              trk1_id;
   logic              trk2_v;
   logic              trk2_id;

`ifdef RAM_ARB_FIXED_PRI_EN
   always_comb begin
      gnt_0 = rst & req_0;
      gnt_1 = rst & req_1 & ~req_0;
   end
`else
   // last = port that transferred most recently; the other port wins a tie
   logic last;

   always_comb begin
      gnt_0 = rst & req_0 & (~req_1 | last);
      gnt_1 = rst & req_1 & (~req_0 | ~last);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (xfer) begin
         last <= xfer_1;
      end
   end
`endif

   always_comb begin
      xfer_0    = req_0 & gnt_0;
      xfer_1    = req_1 & gnt_1;
      xfer      = xfer_0 | xfer_1;
      sel_id    = xfer_1;
      sel_we    = xfer_1 ? we_1    : we_0;
      sel_addr  = xfer_1 ? addr_1  : addr_0;
      sel_wdata = xfer_1 ? wdata_1 : wdata_0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_read   <= 1'b0;
         ram_write  <= 1'b0;
         ram_rd_add <= '0;
         ram_wr_add <= '0;
         ram_d_in   <= '0;
      end else begin
         ram_read  <= xfer & ~sel_we;
         ram_write <= xfer & sel_we;
         if (xfer & sel_we) begin
            ram_wr_add <= sel_addr;
            ram_d_in   <= sel_wdata;
         end
         if (xfer & ~sel_we) begin
            ram_rd_add <= sel_addr;
         end
      end
   end

   // stage 1 mirrors ram_read; stage 2 lines up with ram_d_out being valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trk1_v   <= 1'b0;
         trk1_id  <= 1'b0;
         trk2_v   <= 1'b0;
         trk2_id  <= 1'b0;
         rvalid_0 <= 1'b0;
         rvalid_1 <= 1'b0;
         rdata_0  <= '0;
         rdata_1  <= '0;
      end else begin
         trk1_v   <= xfer & ~sel_we;
         trk1_id  <= sel_id;
         trk2_v   <= trk1_v;
         trk2_id  <= trk1_id;
         rvalid_0 <= trk2_v & ~trk2_id;
         rvalid_1 <= trk2_v & trk2_id;
         if (trk2_v & ~trk2_id) begin
            rdata_0 <= ram_d_out;
         end
         if (trk2_v & trk2_id) begin
            rdata_1 <= ram_d_out;
         end
      end
   end

endmodule

// File: tb/tb_ram_arb_2p.sv
// Scoreboard bench for ram_arb_2p: a reference memory and arbitration rule model predict
// RAM commands and read returns per acceptance; a negedge monitor pops and compares.
module tb_ram_arb_2p;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_0 = 1'b0, req_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
   logic [AW-1:0] addr_0 = '0, addr_1 = '0;
   logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
   logic          gnt_0, gnt_1, rvalid_0, rvalid_1, ram_read, ram_write;
   logic [DW-1:0] rdata_0, rdata_1, ram_d_in;
   logic [AW-1:0] ram_rd_add, ram_wr_add;
   logic [DW-1:0] ram_d_out = '0;

   always #5 clk = ~clk;

   ram_arb_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
      .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
      .rdata_0(rdata_0), .rdata_1(rdata_1),
      .ram_read(ram_read), .ram_write(ram_write),
      .ram_rd_add(ram_rd_add), .ram_wr_add(ram_wr_add),
      .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
   );

   // synchronous RAM device the arbiter drives
   logic [DW-1:0] ram_mem [16];
   always @(posedge clk) begin
      if (ram_write) ram_mem[ram_wr_add] <= ram_d_in;
      if (ram_read)  ram_d_out <= ram_mem[ram_rd_add];
   end

   typedef struct packed {
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;
   typedef struct packed {
      int            cyc;
      logic          port;
      logic [DW-1:0] data;
   } ret_t;

   cmd_t cmd_q[$];
   ret_t ret_q[$];
   cmd_t mc;
   ret_t mr;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rv1_cnt = 0;
   int last_port;
   int base;

   logic [DW-1:0] ref_mem [16];
   logic          model_last;
   logic          pend_v [2];
   logic          pend_we [2];
   logic [AW-1:0] pend_addr [2];
   logic [DW-1:0] pend_wd [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic exp_here;
      check("rw_excl", 64'(ram_read & ram_write), 64'd0);
      if (ram_read || ram_write) begin
         if (cmd_q.size() == 0 || cmd_q[0].cyc != cyc) begin
            check("cmd_unexpected", 64'({ram_read, ram_write}), 64'd0);
         end else begin
            mc = cmd_q.pop_front();
            check("cmd_kind", 64'({ram_read, ram_write}), 64'({~mc.we, mc.we}));
            if (mc.we) begin
               check("cmd_wr_add", 64'(ram_wr_add), 64'(mc.addr));
               check("cmd_d_in", 64'(ram_d_in), 64'(mc.data));
            end else begin
               check("cmd_rd_add", 64'(ram_rd_add), 64'(mc.addr));
            end
         end
      end else if (cmd_q.size() != 0 && cmd_q[0].cyc == cyc) begin
         mc = cmd_q.pop_front();
         check("cmd_missing", 64'({ram_read, ram_write}), 64'({~mc.we, mc.we}));
      end

      if (rvalid_1) rv1_cnt++;
      exp_here = (ret_q.size() != 0 && ret_q[0].cyc == cyc);
      if (exp_here) begin
         mr = ret_q.pop_front();
         check("rvalid", 64'({rvalid_1, rvalid_0}), 64'({mr.port, ~mr.port}));
         if (mr.port) check("rdata_1", 64'(rdata_1), 64'(mr.data));
         else         check("rdata_0", 64'(rdata_0), 64'(mr.data));
      end else if (rvalid_0 || rvalid_1) begin
         check("rvalid_unexpected", 64'({rvalid_1, rvalid_0}), 64'd0);
      end
   end

   task automatic post(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend_v[p] = 1'b1;
      pend_we[p] = we;
      pend_addr[p] = a;
      pend_wd[p] = d;
   endtask

   task automatic accept(input int p);
      cmd_q.push_back('{cyc: cyc + 1, we: pend_we[p], addr: pend_addr[p], data: pend_wd[p]});
      if (pend_we[p]) ref_mem[pend_addr[p]] = pend_wd[p];
      else ret_q.push_back('{cyc: cyc + 3, port: p[0], data: ref_mem[pend_addr[p]]});
      model_last = p[0];
      pend_v[p] = 1'b0;
      last_port = p;
   endtask

   task automatic cycle_once();
      logic eg0, eg1;
      @(negedge clk);
      req_0 = pend_v[0]; we_0 = pend_we[0]; addr_0 = pend_addr[0]; wdata_0 = pend_wd[0];
      req_1 = pend_v[1]; we_1 = pend_we[1]; addr_1 = pend_addr[1]; wdata_1 = pend_wd[1];
      last_port = -1;
      #1;
`ifdef RAM_ARB_FIXED_PRI_EN
      eg0 = pend_v[0];
      eg1 = pend_v[1] && !pend_v[0];
`else
      eg0 = pend_v[0] && (!pend_v[1] || model_last);
      eg1 = pend_v[1] && (!pend_v[0] || !model_last);
`endif
      check("gnt", 64'({gnt_1, gnt_0}), 64'({eg1, eg0}));
      if (eg0) accept(0);
      if (eg1) accept(1);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (pend_v[0] || pend_v[1]); i++) cycle_once();
      if (pend_v[0] || pend_v[1]) check("drain_timeout", 64'({pend_v[1], pend_v[0]}), 64'd0);
      repeat (4) cycle_once();
   endtask

   task automatic rand_req(input int p, input int pct, input bit reads_only);
      if (!pend_v[p] && $urandom_range(0, 99) < pct)
         post(p, reads_only ? 1'b0 : 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
   endtask

   task automatic clear_model();
      cmd_q.delete();
      ret_q.delete();
      pend_v[0] = 1'b0;
      pend_v[1] = 1'b0;
      model_last = 1'b1;
   endtask

   task automatic check_reset_outs(input string name);
      check(name, 64'({ram_read, ram_write, ram_rd_add, ram_wr_add, ram_d_in,
                       rvalid_0, rvalid_1, rdata_0, rdata_1, gnt_0, gnt_1}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int p = 0; p < 2; p++) begin
         pend_we[p] = 1'b0;
         pend_addr[p] = '0;
         pend_wd[p] = '0;
      end
      clear_model();

      // power-on reset
      repeat (3) @(negedge clk);
      req_0 = 1'b1; req_1 = 1'b1;
      #1;
      check_reset_outs("reset_state");
      req_0 = 1'b0; req_1 = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // contention: both ports keep reading
      for (int k = 0; k < 6; k++) begin
         rand_req(0, 100, 1'b1);
         rand_req(1, 100, 1'b1);
         cycle_once();
`ifdef RAM_ARB_FIXED_PRI_EN
         check("contention_seq", 64'(last_port), 64'd0);
`else
         check("contention_seq", 64'(last_port), 64'(k % 2));
`endif
      end
      drain();

      // port 0 writes 0xA5 to addr 3, then reads it back
      post(0, 1'b1, 4'd3, 8'hA5);
      drain();
      post(0, 1'b0, 4'd3, 8'h00);
      drain();
      check("wr_rd_a5", 64'(rdata_0), 64'hA5);

      // back-to-back write/read/read on addr 15
      post(1, 1'b1, 4'd15, 8'h3C);
      cycle_once();
      post(1, 1'b0, 4'd15, 8'h00);
      cycle_once();
      post(0, 1'b0, 4'd15, 8'h00);
      cycle_once();
      drain();
      check("b2b_rdata_1", 64'(rdata_1), 64'h3C);
      check("b2b_rdata_0", 64'(rdata_0), 64'h3C);

      // port 1 read on addr 7 held while port 0 wins first
      post(1, 1'b1, 4'd5, 8'h77);
      drain();
      base = rv1_cnt;
      post(0, 1'b0, 4'd2, 8'h00);
      post(1, 1'b0, 4'd7, 8'h00);
      drain();
      check("hold_rv1_once", 64'(rv1_cnt - base), 64'd1);

      // randomized mixed traffic
      for (int k = 0; k < 400; k++) begin
         rand_req(0, 60, 1'b0);
         rand_req(1, 60, 1'b0);
         cycle_once();
      end
      drain();

      // reads in flight, then asynchronous reset mid-stream
      for (int k = 0; k < 3; k++) begin
         rand_req(0, 100, 1'b1);
         rand_req(1, 100, 1'b1);
         cycle_once();
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      clear_model();
      check_reset_outs("midreset_outs");
      req_0 = 1'b1; req_1 = 1'b1;
      #1;
      check("midreset_gnt", 64'({gnt_1, gnt_0}), 64'd0);
      req_0 = 1'b0; req_1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      base = rv1_cnt;
      repeat (5) cycle_once();
      check("no_rv1_after_reset", 64'(rv1_cnt - base), 64'd0);

      // traffic after reset, round-robin restarts with port 0
      rand_req(0, 100, 1'b1);
      rand_req(1, 100, 1'b1);
      cycle_once();
      check("post_reset_first", 64'(last_port), 64'd0);
      for (int k = 0; k < 100; k++) begin
         rand_req(0, 70, 1'b0);
         rand_req(1, 70, 1'b0);
         cycle_once();
      end
      drain();
      check("queues_empty", 64'(cmd_q.size() + ret_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
